// File: rtl/smart_pkg.sv
// Shared types and default constants for the SmaRT alert/throttle conditioner.
//   smart_state_e        per-channel qualification state
//   DEF_FILTER_CYCLES    synced-level cycles needed to qualify an edge
//   DEF_HOLD_CYCLES      minimum asserted time after qualification
//   DEF_CNT_WIDTH        width of the saturating event counter
package smart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } smart_state_e;

    localparam int unsigned DEF_FILTER_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 200;
    localparam int unsigned DEF_CNT_WIDTH     = 8;

endpackage : smart_pkg

// File: rtl/smart_input_filter.sv
// One conditioning channel: 2-FF synchroniser, glitch filter and minimum-hold
// stretcher for an active-low asynchronous input.
//   iClk     clock
//   iRst     synchronous reset, active-high
//   iEn      low forces the channel idle (outputs deasserted, counters cleared)
//   iRaw_n   raw asynchronous input, active-low
//   oOut_n   conditioned output, active-low, registered
//   oStrobe  1-cycle pulse on the cycle the channel becomes ACTIVE from QUAL
module smart_input_filter
    import smart_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iRaw_n,
    output logic oOut_n,
    output logic oStrobe
);

    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    logic [1:0]    sync;
    logic          synced;
    smart_state_e  state;
    logic [FW-1:0] filt_cnt;
    logic [FW-1:0] filt_inc;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;

    assign synced = sync[1];

    // Saturating increments; neither counter ever wraps.
    assign filt_inc = (filt_cnt == FW'(FILTER_CYCLES)) ? filt_cnt : filt_cnt + FW'(1);
    assign hold_inc = (hold_cnt == HW'(HOLD_CYCLES))   ? hold_cnt : hold_cnt + HW'(1);

    // Synchroniser, qualification FSM and counters.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync     <= 2'b11;
            state    <= IDLE;
            filt_cnt <= '0;
            hold_cnt <= '0;
            oOut_n   <= 1'b1;
            oStrobe  <= 1'b0;
        end else begin
            sync    <= {sync[0], iRaw_n};
            oStrobe <= 1'b0;
            if (!iEn) begin
                // Power-not-ok overrides everything, including an unfinished hold.
                state    <= IDLE;
                filt_cnt <= '0;
                hold_cnt <= '0;
                oOut_n   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!synced) begin
                            state    <= QUAL;
                            filt_cnt <= FW'(1);
                        end
                    end
                    QUAL: begin
                        if (synced) begin
                            state    <= IDLE;
                            filt_cnt <= '0;
                        end else if (filt_inc >= FW'(FILTER_CYCLES)) begin
                            state    <= ACTIVE;
                            filt_cnt <= '0;
                            hold_cnt <= '0;
                            oOut_n   <= 1'b0;
                            oStrobe  <= 1'b1;
                        end else begin
                            filt_cnt <= filt_inc;
                        end
                    end
                    ACTIVE: begin
                        hold_cnt <= hold_inc;
                        if (synced) begin
                            state    <= RELEASE;
                            filt_cnt <= FW'(1);
                        end
                    end
                    RELEASE: begin
                        if (!synced) begin
                            // Re-assertion inside the release window: no new event, hold keeps running.
                            state    <= ACTIVE;
                            filt_cnt <= '0;
                            hold_cnt <= hold_inc;
                        end else if (filt_inc >= FW'(FILTER_CYCLES) && hold_cnt == HW'(HOLD_CYCLES)) begin
                            state    <= IDLE;
                            filt_cnt <= '0;
                            hold_cnt <= '0;
                            oOut_n   <= 1'b1;
                        end else begin
                            filt_cnt <= filt_inc;
                            hold_cnt <= hold_inc;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        filt_cnt <= '0;
                        hold_cnt <= '0;
                        oOut_n   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule : smart_input_filter

// File: rtl/smart_alert_conditioner.sv
// Input conditioning upstream of the SmaRT throttle block: filters and stretches
// the PMBus alert and throttle request, and counts qualified assertions.
//   iClk         2 MHz system clock
//   iRst         synchronous reset, active-high
//   iAlert_n     raw PMBus alert, asynchronous, active-low
//   iThrottle_n  raw throttle request, asynchronous, active-low
//   iPwrOk       low forces both channels idle; event count is kept
//   iCountClr    1-cycle pulse clearing oEventCount (wins over a coincident event)
//   oAlert_n     conditioned alert, active-low
//   oThrottle_n  conditioned throttle, active-low
//   oEvent       1-cycle pulse on any new qualified assertion
//   oEventCount  saturating count of qualified assertions
module smart_alert_conditioner
    import smart_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iAlert_n,
    input  logic                 iThrottle_n,
    input  logic                 iPwrOk,
    input  logic                 iCountClr,
    output logic                 oAlert_n,
    output logic                 oThrottle_n,
    output logic                 oEvent,
    output logic [CNT_WIDTH-1:0] oEventCount
);

    logic             strobe_alert;
    logic             strobe_throttle;
    logic [1:0]       strobe_num;
    logic [CNT_WIDTH:0] count_sum;
    logic [CNT_WIDTH-1:0] count_next;

    smart_input_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_alert_filter (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (iPwrOk),
        .iRaw_n  (iAlert_n),
        .oOut_n  (oAlert_n),
        .oStrobe (strobe_alert)
    );

    smart_input_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_throttle_filter (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (iPwrOk),
        .iRaw_n  (iThrottle_n),
        .oOut_n  (oThrottle_n),
        .oStrobe (strobe_throttle)
    );

    // Add 0/1/2 events with one extra carry bit so saturation can be detected.
    always_comb begin
        strobe_num = {1'b0, strobe_alert} + {1'b0, strobe_throttle};
        count_sum  = {1'b0, oEventCount} + (CNT_WIDTH + 1)'(strobe_num);
        count_next = count_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : count_sum[CNT_WIDTH-1:0];
    end

    // Event pulse and saturating event counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oEvent      <= 1'b0;
            oEventCount <= '0;
        end else begin
            oEvent      <= strobe_alert | strobe_throttle;
            oEventCount <= iCountClr ? '0 : count_next;
        end
    end

endmodule : smart_alert_conditioner

// File: tb/tb_smart_alert_conditioner.sv
module tb_smart_alert_conditioner;

    localparam int F = 4;
    localparam int H = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alert_in = 1'b1;
    logic       thr_in = 1'b1;
    logic       pwrok = 1'b1;
    logic       count_clr = 1'b0;
    logic       alert_n;
    logic       thr_n;
    logic       event_o;
    logic [7:0] count;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: per channel, a 2-deep delay line, an "asserted" flag,
    // the current run length of the opposing level, and cycles since assertion.
    bit m_s1[2];
    bit m_s2[2];
    bit m_act[2];
    int m_run[2];
    int m_since[2];
    bit m_stb[2];
    bit m_event;
    int m_count;

    smart_alert_conditioner dut (
        .iClk        (clk),
        .iRst        (rst),
        .iAlert_n    (alert_in),
        .iThrottle_n (thr_in),
        .iPwrOk      (pwrok),
        .iCountClr   (count_clr),
        .oAlert_n    (alert_n),
        .oThrottle_n (thr_n),
        .oEvent      (event_o),
        .oEventCount (count)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit s;
        bit raw;
        int n;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_act[c] = 1'b0;
                m_run[c] = 0; m_since[c] = 0; m_stb[c] = 1'b0;
            end
            m_event = 1'b0;
            m_count = 0;
        end else begin
            n = int'(m_stb[0]) + int'(m_stb[1]);
            m_event = (n != 0);
            if (count_clr) m_count = 0;
            else m_count = (m_count + n > 255) ? 255 : m_count + n;
            for (int c = 0; c < 2; c++) begin
                raw = (c == 0) ? alert_in : thr_in;
                s = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw;
                m_stb[c] = 1'b0;
                if (!pwrok) begin
                    m_act[c] = 1'b0; m_run[c] = 0; m_since[c] = 0;
                end else if (!m_act[c]) begin
                    if (!s) begin
                        m_run[c]++;
                        if (m_run[c] >= F) begin
                            m_act[c] = 1'b1; m_run[c] = 0; m_since[c] = 0; m_stb[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    if (s) begin
                        m_run[c]++;
                        if (m_run[c] >= F && m_since[c] >= H) begin
                            m_act[c] = 1'b0; m_run[c] = 0; m_since[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (m_act[c]) m_since[c] = (m_since[c] < H) ? m_since[c] + 1 : H;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (alert_n !== 1'b1 || thr_n !== 1'b1 || event_o !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL reset: got a=%b t=%b e=%b c=%0d want a=1 t=1 e=0 c=0", alert_n, thr_n, event_o, count);
        end
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_glitch();
        alert_in = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) alert_in = 1'b1;
            tick();
            checks++;
            if (alert_n !== 1'b1 || event_o !== 1'b0) begin
                errors++;
                $display("FAIL glitch k=%0d: got a=%b e=%b want a=1 e=0", k, alert_n, event_o);
            end
        end
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_count: got %0d want 0", count);
        end
    endtask

    task automatic test_qualify();
        int rise;
        rise = -1;
        thr_in = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 11) thr_in = 1'b1;
            tick();
            checks++;
            if (alert_n !== ~m_act[0] || thr_n !== ~m_act[1] || event_o !== m_event || count !== 8'(m_count)) begin
                errors++;
                $display("FAIL qualify_model k=%0d: got a=%b t=%b e=%b c=%0d want a=%b t=%b e=%b c=%0d",
                         k, alert_n, thr_n, event_o, count, ~m_act[0], ~m_act[1], m_event, m_count);
            end
            if (k <= 10) begin
                checks++;
                if (thr_n !== ((k >= 6) ? 1'b0 : 1'b1) || event_o !== (k == 7)) begin
                    errors++;
                    $display("FAIL qualify_latency k=%0d: got t=%b e=%b", k, thr_n, event_o);
                end
            end else if (thr_n === 1'b1) begin
                rise = k;
                break;
            end
        end
        checks++;
        if (rise != 207 || count !== 8'd1) begin
            errors++;
            $display("FAIL qualify_release: got edge=%0d count=%0d want edge=207 count=1", rise, count);
        end
    endtask

    task automatic test_long_hold();
        int pulses;
        bit  stayed;
        thr_in = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            tick();
            checks++;
            if (thr_n !== ~m_act[1] || event_o !== m_event || count !== 8'(m_count)) begin
                errors++;
                $display("FAIL long_model k=%0d: got t=%b e=%b c=%0d want t=%b e=%b c=%0d",
                         k, thr_n, event_o, count, ~m_act[1], m_event, m_count);
            end
        end
        thr_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (thr_n !== ((k >= 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL long_release k=%0d: got t=%b", k, thr_n);
            end
        end
        // Fresh assertion, then a short low blip while releasing.
        thr_in = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        pulses = 0;
        stayed = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            thr_in = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            tick();
            pulses += int'(event_o);
            if (k <= 20 && thr_n !== 1'b0) stayed = 1'b0;
            checks++;
            if (thr_n !== ~m_act[1] || event_o !== m_event || count !== 8'(m_count)) begin
                errors++;
                $display("FAIL blip_model k=%0d: got t=%b e=%b c=%0d want t=%b e=%b c=%0d",
                         k, thr_n, event_o, count, ~m_act[1], m_event, m_count);
            end
        end
        checks++;
        if (pulses != 0 || !stayed || thr_n !== 1'b1) begin
            errors++;
            $display("FAIL blip: got pulses=%0d held=%b final_t=%b want pulses=0 held=1 final_t=1", pulses, stayed, thr_n);
        end
    endtask

    task automatic test_both_saturate();
        int exp_cnt;
        int pulses;
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            alert_in = 1'b0; thr_in = 1'b0;
            pulses = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                pulses += int'(event_o);
            end
            exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
            checks++;
            if (pulses != 1 || count !== 8'(exp_cnt) || alert_n !== 1'b0 || thr_n !== 1'b0) begin
                errors++;
                $display("FAIL both i=%0d: got pulses=%0d c=%0d a=%b t=%b want pulses=1 c=%0d a=0 t=0",
                         i, pulses, count, alert_n, thr_n, exp_cnt);
            end
            alert_in = 1'b1; thr_in = 1'b1;
            tick(); tick(); tick();
            pwrok = 1'b0; tick(); pwrok = 1'b1;
            tick(); tick();
        end
        checks++;
        if (count !== 8'd255 || count !== 8'(m_count)) begin
            errors++;
            $display("FAIL saturate: got %0d want 255", count);
        end
    endtask

    task automatic test_pwrok();
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        alert_in = 1'b0;
        for (int k = 1; k <= 56; k++) tick();
        checks++;
        if (alert_n !== 1'b0 || count !== 8'd1) begin
            errors++;
            $display("FAIL pwrok_pre: got a=%b c=%0d want a=0 c=1", alert_n, count);
        end
        pwrok = 1'b0;
        tick();
        checks++;
        if (alert_n !== 1'b1 || count !== 8'd1 || event_o !== 1'b0) begin
            errors++;
            $display("FAIL pwrok_drop: got a=%b c=%0d e=%b want a=1 c=1 e=0", alert_n, count, event_o);
        end
        tick(); tick();
        pwrok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (alert_n !== ((k >= 4) ? 1'b0 : 1'b1) || alert_n !== ~m_act[0]) begin
                errors++;
                $display("FAIL pwrok_requal k=%0d: got a=%b", k, alert_n);
            end
        end
        checks++;
        if (count !== 8'd2) begin
            errors++;
            $display("FAIL pwrok_count: got %0d want 2", count);
        end
        alert_in = 1'b1;
        tick(); tick(); tick();
        pwrok = 1'b0; tick(); pwrok = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_clear_and_reset();
        thr_in = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        checks++;
        if (event_o !== 1'b1 || count !== 8'd0 || thr_n !== 1'b0) begin
            errors++;
            $display("FAIL clear_vs_event: got e=%b c=%0d t=%b want e=1 c=0 t=0", event_o, count, thr_n);
        end
        alert_in = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (alert_n !== 1'b1 || thr_n !== 1'b1 || event_o !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got a=%b t=%b e=%b c=%0d want a=1 t=1 e=0 c=0", alert_n, thr_n, event_o, count);
        end
        rst = 1'b0;
        alert_in = 1'b1; thr_in = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
    endtask

    task automatic test_random();
        int rem[2];
        int pw_rem;
        rem[0] = 1; rem[1] = 1; pw_rem = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < 2; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    if (c == 0) alert_in = ~alert_in; else thr_in = ~thr_in;
                    rem[c] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 6)) : int'($urandom_range(7, 260));
                end
            end
            if (pw_rem > 0) pw_rem--;
            else if ($urandom_range(0, 199) == 0) pw_rem = int'($urandom_range(1, 3));
            pwrok = (pw_rem == 0);
            count_clr = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (alert_n !== ~m_act[0] || thr_n !== ~m_act[1] || event_o !== m_event || count !== 8'(m_count)) begin
                errors++;
                $display("FAIL random k=%0d: got a=%b t=%b e=%b c=%0d want a=%b t=%b e=%b c=%0d",
                         k, alert_n, thr_n, event_o, count, ~m_act[0], ~m_act[1], m_event, m_count);
            end
        end
        pwrok = 1'b1; count_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_qualify();
        test_long_hold();
        test_both_saturate();
        test_pwrok();
        test_clear_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_smart_alert_conditioner
